// File: rtl/score_event_arbiter.sv
// Round-robin arbiter sharing one scoring engine among N tip sources.
// Issues one registered tip pulse per handshake, enforces a minimum gap and counts events.
module score_event_arbiter #(
   parameter int N       = 4,
   parameter int MIN_GAP = 0,
   parameter int IDW     = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_valid,
   input  logic [N*8-1:0] req_delta,
   output logic [N-1:0]   req_ready,
   input  logic           freeze,
   output logic           tip_event_valid,
   output logic [7:0]     tip_delta,
   output logic [IDW-1:0] grant_id,
   output logic [15:0]    total_issued,
   output logic           gap_active
);

   localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
   logic           tip_event_valid_q, tip_event_valid_d;
   logic [7:0]     tip_delta_q, tip_delta_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic [15:0]    total_issued_q, total_issued_d;

   logic           eligible;
   logic           found;
   logic [IDW-1:0] winner;
   logic [IDW:0]   cand;
   logic           transfer;

   // Ready is suppressed during reset, freeze and while the gap counter runs.
   assign eligible = rst_n && !freeze && (gap_cnt_q == '0);

   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
         if (!found && req_valid[cand[IDW-1:0]]) begin
            found  = 1'b1;
            winner = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N; i++) begin
         req_ready[i] = eligible && found && (winner == IDW'(i));
      end
   end

   assign transfer = eligible && found;

   always_comb begin
      tip_event_valid_d = transfer;
      tip_delta_d       = tip_delta_q;
      grant_id_d        = grant_id_q;
      rr_ptr_d          = rr_ptr_q;
      gap_cnt_d         = gap_cnt_q;
      total_issued_d    = total_issued_q;
      if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
      if (transfer) begin
         tip_delta_d = req_delta[{winner, 3'b000} +: 8];
         grant_id_d  = winner;
         rr_ptr_d    = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
         gap_cnt_d   = GW'(MIN_GAP);
         if (total_issued_q != 16'hFFFF) total_issued_d = total_issued_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q          <= '0;
         gap_cnt_q         <= '0;
         tip_event_valid_q <= 1'b0;
         tip_delta_q       <= '0;
         grant_id_q        <= '0;
         total_issued_q    <= '0;
      end else begin
         rr_ptr_q          <= rr_ptr_d;
         gap_cnt_q         <= gap_cnt_d;
         tip_event_valid_q <= tip_event_valid_d;
         tip_delta_q       <= tip_delta_d;
         grant_id_q        <= grant_id_d;
         total_issued_q    <= total_issued_d;
      end
   end

   assign tip_event_valid = tip_event_valid_q;
   assign tip_delta       = tip_delta_q;
   assign grant_id        = grant_id_q;
   assign total_issued    = total_issued_q;
   assign gap_active      = (gap_cnt_q != '0);

endmodule

// File: tb/tb_score_event_arbiter.sv
// Bench for score_event_arbiter: directed sequences on a MIN_GAP=0 and a MIN_GAP=2 instance,
// with queued expected pulses popped by negedge monitors.
module tb_score_event_arbiter;

   logic        clk;
   logic        rst_n;

   logic [3:0]  v0, r0, v2, r2;
   logic [31:0] d0, d2;
   logic        f0, f2;
   logic        tv0, tv2, ga0, ga2;
   logic [7:0]  td0, td2;
   logic [1:0]  gid0, gid2;
   logic [15:0] tot0, tot2;

   logic [9:0]  exp_q0[$];
   logic [9:0]  exp_q2[$];

   int checks = 0;
   int errors = 0;

   score_event_arbiter #(.N(4), .MIN_GAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_delta(d0), .req_ready(r0),
      .freeze(f0), .tip_event_valid(tv0), .tip_delta(td0), .grant_id(gid0),
      .total_issued(tot0), .gap_active(ga0)
   );

   score_event_arbiter #(.N(4), .MIN_GAP(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_delta(d2), .req_ready(r2),
      .freeze(f2), .tip_event_valid(tv2), .tip_delta(td2), .grant_id(gid2),
      .total_issued(tot2), .gap_active(ga2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      v0 = '0; v2 = '0; f0 = 1'b0; f2 = 1'b0;
      rst_n = 1'b0;
      exp_q0.delete();
      exp_q2.delete();
      tick();
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin : mon0
      logic [9:0] e;
      if (rst_n && tv0) begin
         if (exp_q0.size() == 0) check("dut0_unexpected_pulse", 32'd1, 32'd0);
         else begin
            e = exp_q0.pop_front();
            check("dut0_pulse", {22'd0, gid0, td0}, {22'd0, e});
         end
      end
   end

   always @(negedge clk) begin : mon2
      logic [9:0] e;
      if (rst_n && tv2) begin
         if (exp_q2.size() == 0) check("dut2_unexpected_pulse", 32'd1, 32'd0);
         else begin
            e = exp_q2.pop_front();
            check("dut2_pulse", {22'd0, gid2, td2}, {22'd0, e});
         end
      end
   end

   logic [3:0] rr_ready [6];
   logic [9:0] rr_exp   [6];

   initial begin
      rr_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      rr_exp   = '{{2'd0, 8'h01}, {2'd1, 8'h02}, {2'd2, 8'hFD},
                   {2'd3, 8'h04}, {2'd0, 8'h01}, {2'd1, 8'h02}};

      // Reset state, with requests pending to show ready stays low
      rst_n = 1'b0; v0 = 4'b1111; d0 = 32'h04FD0201; f0 = 1'b0;
      v2 = 4'b1111; d2 = '0; f2 = 1'b0;
      #1;
      check("rst_valid", {31'd0, tv0}, 32'd0);
      check("rst_delta", {24'd0, td0}, 32'd0);
      check("rst_gid", {30'd0, gid0}, 32'd0);
      check("rst_total", {16'd0, tot0}, 32'd0);
      check("rst_ready", {28'd0, r0}, 32'd0);
      check("rst_ready2", {28'd0, r2}, 32'd0);
      check("rst_gap", {31'd0, ga2}, 32'd0);
      tick();
      v0 = '0; v2 = '0;
      rst_n = 1'b1;

      // Single source
      v0 = 4'b0001; d0 = 32'h0000_0005;
      #1;
      check("single_ready", {28'd0, r0}, 32'b0001);
      exp_q0.push_back({2'd0, 8'h05});
      tick();
      check("single_pulse", {31'd0, tv0}, 32'd1);
      check("single_delta", {24'd0, td0}, 32'h05);
      check("single_gid", {30'd0, gid0}, 32'd0);
      check("single_total", {16'd0, tot0}, 32'd1);
      v0 = '0;
      #1;
      check("single_ready_off", {28'd0, r0}, 32'd0);
      tick();
      check("single_pulse_end", {31'd0, tv0}, 32'd0);

      // Round-robin with all sources valid
      do_reset();
      v0 = 4'b1111; d0 = 32'h04FD0201;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("rr_ready", {28'd0, r0}, {28'd0, rr_ready[k]});
         exp_q0.push_back(rr_exp[k]);
         tick();
         check("rr_pulse", {31'd0, tv0}, 32'd1);
      end
      v0 = '0;
      check("rr_total", {16'd0, tot0}, 32'd6);

      // Minimum gap of 2 on the second instance
      do_reset();
      v2 = 4'b0010; d2 = 32'h0000_0700;
      for (int p = 0; p < 3; p++) begin
         #1;
         check("gap_ready_open", {28'd0, r2}, 32'b0010);
         check("gap_idle", {31'd0, ga2}, 32'd0);
         exp_q2.push_back({2'd1, 8'h07});
         tick();
         check("gap_pulse", {31'd0, tv2}, 32'd1);
         check("gap_active1", {31'd0, ga2}, 32'd1);
         check("gap_ready1", {28'd0, r2}, 32'd0);
         tick();
         check("gap_no_pulse", {31'd0, tv2}, 32'd0);
         check("gap_active2", {31'd0, ga2}, 32'd1);
         check("gap_ready2", {28'd0, r2}, 32'd0);
         tick();
      end
      v2 = '0;
      check("gap_total", {16'd0, tot2}, 32'd3);

      // Freeze after a grant to source 2
      do_reset();
      v0 = 4'b0100; d0 = 32'h3322_0011;
      #1;
      check("frz_first_ready", {28'd0, r0}, 32'b0100);
      exp_q0.push_back({2'd2, 8'h22});
      tick();
      f0 = 1'b1; v0 = 4'b1001;
      #1;
      check("frz_pulse_survives", {31'd0, tv0}, 32'd1);
      check("frz_ready_drop", {28'd0, r0}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("frz_no_pulse", {31'd0, tv0}, 32'd0);
         check("frz_no_ready", {28'd0, r0}, 32'd0);
      end
      f0 = 1'b0;
      #1;
      check("frz_release_ready", {28'd0, r0}, 32'b1000);
      exp_q0.push_back({2'd3, 8'h33});
      tick();
      check("frz_release_gid", {30'd0, gid0}, 32'd3);
      v0 = '0;

      // Reset while a pulse is on the output
      v0 = 4'b0100;
      #1;
      exp_q0.push_back({2'd2, 8'h22});
      tick();
      check("rstmid_pulse", {31'd0, tv0}, 32'd1);
      rst_n = 1'b0;
      exp_q0.delete();
      #1;
      check("rstmid_valid", {31'd0, tv0}, 32'd0);
      check("rstmid_delta", {24'd0, td0}, 32'd0);
      check("rstmid_gid", {30'd0, gid0}, 32'd0);
      check("rstmid_total", {16'd0, tot0}, 32'd0);
      check("rstmid_ready", {28'd0, r0}, 32'd0);
      tick();
      rst_n = 1'b1; v0 = 4'b1111; d0 = 32'h04FD0201;
      #1;
      check("rstmid_first_ready", {28'd0, r0}, 32'b0001);
      exp_q0.push_back({2'd0, 8'h01});
      tick();
      check("rstmid_first_gid", {30'd0, gid0}, 32'd0);
      check("rstmid_first_total", {16'd0, tot0}, 32'd1);
      v0 = '0;

      // Saturation with zero-delta events
      do_reset();
      v0 = 4'b0001; d0 = 32'h0000_0000;
      for (int i = 0; i < 65535; i++) begin
         exp_q0.push_back({2'd0, 8'h00});
         tick();
      end
      check("sat_reach", {16'd0, tot0}, 32'h0000FFFF);
      for (int i = 0; i < 2; i++) begin
         exp_q0.push_back({2'd0, 8'h00});
         tick();
         check("sat_pulse", {31'd0, tv0}, 32'd1);
         check("sat_hold", {16'd0, tot0}, 32'h0000FFFF);
      end
      v0 = '0;
      tick();
      check("sat_pulse_end", {31'd0, tv0}, 32'd0);

      tick();
      tick();
      check("q0_drained", exp_q0.size(), 32'd0);
      check("q2_drained", exp_q2.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
